sha3_pad_absorb: RTL
====================

Name: sha3_pad_absorb

Overview:
Upstream feeder for the SHA3-512 permutation stage (rate 576 bits = 9 lanes, capacity 1024).
- Accepts a message as a stream of 64-bit little-endian words over a valid/ready handshake.
- Packs the words into 576-bit rate blocks and applies SHA-3 multi-rate padding (domain byte 0x06, final bit 0x80).
- Presents each completed block to the permutation through a block-level valid/ready handshake, flagging the final block of the message.

Parameters:
RATE_LANES, 9, number of 64-bit lanes per rate block (576 bits).
LANE_W, 64, lane and input word width in bits.
DOMAIN_BYTE, 8'h06, SHA-3 domain-separation pad byte.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
in_data  input  64  message word; byte 0 in bits [7:0].
in_valid  input  1  in_data / in_last / in_nbytes are valid.
in_last  input  1  current word is the last of the message.
in_nbytes  input  4  valid bytes in the last word (0..8); must be 8 when in_last=0.
in_ready  output  1  block can accept a word this cycle.
blk_data  output  576  rate block; lane k is at bits [64k+63:64k].
blk_valid  output  1  blk_data is valid and held stable.
blk_last  output  1  blk_data is the final padded block of the message.
blk_ready  input  1  permutation stage accepts the block.

Behaviour:
- Reset (rst=0, asynchronous): state=FILL, lane counter=0, buffer=0, extra-pad flag=0, in_ready=1, blk_valid=0, blk_last=0, blk_data=0.
- States are FILL, EMIT and PAD_EXTRA.
- FILL:
  - in_ready=1; blk_valid=0.
  - On in_valid&in_ready, the word is written to lane[cnt].
  - Bytes at index >= in_nbytes of a last word are forced to 0 before the pad is applied.
- Padding is XORed into the buffer:
  - DOMAIN_BYTE goes to byte (8*cnt + in_nbytes).
  - 0x80 goes to byte 71 (bits [575:568]).
  - When both land on byte 71, that byte becomes 0x86.
- Transitions out of FILL on an accepted word:
  - Not last and cnt<8: cnt+=1, stay in FILL.
  - Not last and cnt==8: go to EMIT with blk_last=0.
  - Last and in_nbytes<8, or last and cnt<8: pad in place; unfilled lanes stay 0; go to EMIT with blk_last=1.
    - Case last, cnt<8, in_nbytes==8: the pad byte goes to byte 0 of lane cnt+1.
  - Last and cnt==8 and in_nbytes==8: go to EMIT with blk_last=0 and set the extra-pad flag.
- EMIT:
  - blk_valid=1 from the cycle after the completing word is accepted (1-cycle latency).
  - in_ready=0.
  - blk_data and blk_last are held stable until blk_ready.
  - On blk_valid&blk_ready: clear the buffer and set cnt=0.
    - If the extra-pad flag is set: clear the flag and go to PAD_EXTRA.
    - Otherwise go to FILL.
  - blk_valid drops the cycle after the handshake unless the next block is already complete (it cannot be, because in_ready=0 in EMIT).
- PAD_EXTRA: one cycle.
  - Buffer is set to byte0=DOMAIN_BYTE and byte71=0x80, all else 0.
  - blk_last=1; go to EMIT.
- Empty message (first word has in_last=1, in_nbytes=0): one block with byte0=0x06, byte71=0x80, blk_last=1.
- in_nbytes>8 is illegal and is treated as 8. in_nbytes on non-last words is ignored (full word used).
- Reset mid-operation discards any partial or pending block immediately, including while blk_valid=1.
- blk_data exposes the internal buffer directly (registered output, no combinational path from in_data).

Test Plan:
1. Single word "abc" (in_data=64'h636261, in_nbytes=3, in_last=1), blk_ready=1 -> one block with lane0=64'h0000_0000_0663_6261, bits[575:568]=8'h80, all other bits 0, blk_last=1; blk_valid rises 1 cycle after acceptance.
2. Empty message (in_last=1, in_nbytes=0) -> lane0=64'h06, byte71=8'h80, blk_last=1.
3. 71 bytes (9 words, last in_nbytes=7) -> single block with byte71=8'h86, blk_last=1.
4. 72 bytes (9 full words, last in_nbytes=8) -> block 1 carries the data with blk_last=0; then PAD_EXTRA produces block 2 (byte0=0x06, byte71=0x80, blk_last=1).
5. 150-byte message with blk_ready held low 20 cycles per block -> blk_data stable while stalled, in_ready=0 throughout EMIT, no input word lost or duplicated; 3 blocks emitted, only the third with blk_last=1.
6. Assert rst low after 4 words accepted, and again while blk_valid=1 -> blk_valid=0 and in_ready=1 immediately; next message "abc" produces exactly the block from test 1.

Source files
------------

// File: rtl/sha3_pad_absorb_if.sv
// Handshake bundle between the message source, the SHA3 pad/absorb block and
// the permutation stage.
//   in_*  : 64-bit little-endian message words, valid/ready, last flag and
//           byte count of the last word.
//   blk_* : completed 576-bit rate block, valid/ready, final-block flag.
// master: message source / permutation side. slave: sha3_pad_absorb.
interface sha3_pad_absorb_if #(
  parameter int unsigned RATE_LANES = 9,
  parameter int unsigned LANE_W     = 64
);
  localparam int unsigned BLK_W = RATE_LANES * LANE_W;

  logic [LANE_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic [3:0]        in_nbytes;
  logic              in_ready;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_valid;
  logic              blk_last;
  logic              blk_ready;

  modport master (
    output in_data, in_valid, in_last, in_nbytes, blk_ready,
    input  in_ready, blk_data, blk_valid, blk_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_nbytes, blk_ready,
    output in_ready, blk_data, blk_valid, blk_last
  );
endinterface

// File: rtl/sha3_pad_absorb.sv
// SHA3-512 pad/absorb feeder: packs 64-bit message words into 576-bit rate
// blocks, applies SHA-3 multi-rate padding and hands each block to the
// permutation stage over a block-level valid/ready handshake.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : sha3_pad_absorb_if slave (in_* word stream in, blk_* block out)
module sha3_pad_absorb #(
  parameter int unsigned RATE_LANES  = 9,
  parameter int unsigned LANE_W      = 64,
  parameter logic [7:0]  DOMAIN_BYTE = 8'h06
) (
  input logic             clk,
  input logic             rst,
  sha3_pad_absorb_if.slave bus
);

  localparam int unsigned WORD_BYTES = LANE_W / 8;
  localparam int unsigned BLK_W      = RATE_LANES * LANE_W;
  localparam int unsigned BLK_BYTES  = BLK_W / 8;
  localparam int unsigned CNT_W      = $clog2(RATE_LANES);
  localparam int unsigned POS_W      = $clog2(BLK_BYTES + 1);
  localparam int unsigned NB_W       = 4;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);
  localparam logic [BLK_W-1:0] EXTRA_BLK =
    {8'h80, {(BLK_W - 16){1'b0}}, DOMAIN_BYTE};

  typedef enum logic [1:0] {FILL, EMIT, PAD_EXTRA} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BLK_W-1:0] buffer;
  logic             extra_pad;
  logic             in_ready_r;
  logic             blk_valid_r;
  logic             blk_last_r;

  logic [NB_W-1:0]   nb;
  logic              full_last;
  logic              pad_en;
  logic [POS_W-1:0]  pad_pos;
  logic [LANE_W-1:0] word;
  logic [BLK_W-1:0]  fill_buf;

  assign bus.in_ready  = in_ready_r;
  assign bus.blk_data  = buffer;
  assign bus.blk_valid = blk_valid_r;
  assign bus.blk_last  = blk_last_r;

  // Effective byte count: full word unless last; out-of-range counts clamp to a full word.
  always_comb begin
    nb = NB_W'(WORD_BYTES);
    if (bus.in_last && (bus.in_nbytes < NB_W'(WORD_BYTES))) begin
      nb = bus.in_nbytes;
    end
  end

  // A full last word in the last lane leaves no room for padding: pad goes to an extra block.
  assign full_last = bus.in_last && (cnt == LAST_LANE) && (nb == NB_W'(WORD_BYTES));
  assign pad_en    = bus.in_last && !full_last;
  assign pad_pos   = POS_W'(cnt) * POS_W'(WORD_BYTES) + POS_W'(nb);

  // Zero the bytes past the valid count of the incoming word.
  always_comb begin
    word = '0;
    for (int j = 0; j < int'(WORD_BYTES); j++) begin
      if (NB_W'(j) < nb) begin
        word[j*8 +: 8] = bus.in_data[j*8 +: 8];
      end
    end
  end

  // Buffer contents after accepting the current word, including padding on the last word.
  always_comb begin
    fill_buf = buffer;
    for (int k = 0; k < int'(RATE_LANES); k++) begin
      if (cnt == CNT_W'(k)) begin
        fill_buf[k*LANE_W +: LANE_W] = word;
      end
    end
    if (pad_en) begin
      for (int b = 0; b < int'(BLK_BYTES); b++) begin
        if (pad_pos == POS_W'(b)) begin
          fill_buf[b*8 +: 8] = fill_buf[b*8 +: 8] ^ DOMAIN_BYTE;
        end
      end
      // XOR lets the domain byte and final bit merge into 0x86 when both hit the last byte.
      fill_buf[BLK_W-1 -: 8] = fill_buf[BLK_W-1 -: 8] ^ 8'h80;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FILL;
      cnt         <= '0;
      buffer      <= '0;
      extra_pad   <= 1'b0;
      in_ready_r  <= 1'b1;
      blk_valid_r <= 1'b0;
      blk_last_r  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid && in_ready_r) begin
            buffer <= fill_buf;
            if (bus.in_last || (cnt == LAST_LANE)) begin
              state       <= EMIT;
              in_ready_r  <= 1'b0;
              blk_valid_r <= 1'b1;
              blk_last_r  <= pad_en;
              extra_pad   <= full_last;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (bus.blk_ready) begin
            buffer      <= '0;
            cnt         <= '0;
            blk_valid_r <= 1'b0;
            blk_last_r  <= 1'b0;
            if (extra_pad) begin
              extra_pad <= 1'b0;
              state     <= PAD_EXTRA;
            end else begin
              in_ready_r <= 1'b1;
              state      <= FILL;
            end
          end
        end
        PAD_EXTRA: begin
          buffer      <= EXTRA_BLK;
          blk_last_r  <= 1'b1;
          blk_valid_r <= 1'b1;
          state       <= EMIT;
        end
        default: begin
          state      <= FILL;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule
